// File: rtl/reg_pipeline.sv
// reg_pipeline: DEPTH-stage, WIDTH-bit register pipeline with a valid/ready
// handshake. Empty stages keep filling while the output is stalled, so bubbles
// do not hold up upstream data.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   ce                global clock enable (all state holds when low)
//   flush             synchronous clear of every stage (only on an enabled edge)
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake, driven by the last stage
//   count             number of valid stages, 0..DEPTH

// One pipeline stage: valid bit plus a data register that loads only when the
// incoming valid is set, so a bubble never overwrites held data.
module reg_pipeline_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             adv,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (clr) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else if (en && adv) begin
      v <= vin;
      if (vin) d <= din;
    end
  end
endmodule

module reg_pipeline #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            adv;
  logic                        en, clr, acc_in, acc_out;
  logic [CNT_W-1:0]            count_q;

  assign en  = ce & ~flush;
  assign clr = ce & flush;

  // A stage may advance if it is empty or the stage ahead of it advances;
  // this is what lets bubbles collapse behind a stalled output.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~v[DEPTH-1] | out_ready;
    for (int i = DEPTH-2; i >= 0; i--)
      adv[i] = ~v[i] | adv[i+1];
  end

  // Reset clears v asynchronously, which would make adv[0]=1; gate with rst
  // so in_ready stays low for as long as reset is held.
  assign in_ready = ~rst & en & adv[0];
  assign acc_in   = in_ready & in_valid;
  assign acc_out  = en & v[DEPTH-1] & out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;
    if (i == 0) begin : g_head
      assign vin = in_valid;
      assign din = in_data;
    end else begin : g_body
      assign vin = v[i-1];
      assign din = d[i-1];
    end
    reg_pipeline_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .adv(adv[i]),
      .vin(vin), .din(din), .v(v[i]), .d(d[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else if (clr)
      count_q <= '0;
    else if (en)
      count_q <= count_q + CNT_W'(acc_in) - CNT_W'(acc_out);
  end

  assign count     = count_q;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule

// File: tb/tb_reg_pipeline.sv
module tb_reg_pipeline;
  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0] count;

  int npass = 0, ntot = 0;

  reg_pipeline #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .ce(ce), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the pipeline contents are an ordered list of items, each with a
  // stage position. The j-th oldest item can sit no further forward than
  // DEPTH-1-j; otherwise there is a free slot ahead and it moves one stage.
  typedef struct { logic [7:0] data; int pos; } item_t;
  item_t q[$];
  logic [7:0] m_last = RV;   // data most recently delivered into the last stage

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_last = RV;
    end else if (ce) begin
      if (flush) begin
        q.delete();
        m_last = RV;
      end else begin
        automatic bit acc = in_valid && (q.size() < D || out_ready);
        if (q.size() > 0 && q[0].pos == D-1 && out_ready) void'(q.pop_front());
        for (int j = 0; j < q.size(); j++) begin
          automatic item_t it = q[j];
          automatic int lim = D-1-j;
          automatic int np = (it.pos + 1 < lim) ? it.pos + 1 : lim;
          if (np == D-1 && it.pos != D-1) m_last = it.data;
          it.pos = np;
          q[j] = it;
        end
        if (acc) begin
          automatic item_t ni;
          ni.data = in_data;
          ni.pos  = 0;
          if (D == 1) m_last = in_data;
          q.push_back(ni);
        end
      end
    end
  end

  function automatic logic m_ovalid();
    return q.size() > 0 && q[0].pos == D-1;
  endfunction

  function automatic logic m_iready();
    return !rst && ce && !flush && (q.size() < D || out_ready);
  endfunction

  always @(negedge clk) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_ovalid()});
    chk("out_data",  {24'b0, out_data},  {24'b0, m_last});
    chk("count",     {30'b0, count},     q.size());
    chk("in_ready",  {31'b0, in_ready},  {31'b0, m_iready()});
  end

  task automatic set(input logic c, input logic f, input logic iv,
                     input logic [7:0] id, input logic ordy);
    ce = c; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    set(1, 0, 0, 0, 1);
    repeat (D+1) tick();
  endtask

  initial begin
    logic [1:0] cnt_hold;
    // reset release
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set(1, 0, 0, 0, 0);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_data", {24'b0, out_data}, 32'hA5);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_count", {30'b0, count}, 0);

    // streaming: latency D, one transfer per cycle
    for (int k = 1; k <= 9; k++) begin
      set(1, 0, (k <= 6), 8'(k), 1);
      tick();
      if (k < 3) chk("stream_lat", {31'b0, out_valid}, 0);
      else if (k <= 8) begin
        chk("stream_valid", {31'b0, out_valid}, 1);
        chk("stream_data", {24'b0, out_data}, k - 2);
        if (k <= 6) chk("stream_count", {30'b0, count}, 3);
      end
    end
    drain();

    // fill with stalled output, then release one
    for (int k = 1; k <= 3; k++) begin
      set(1, 0, 1, 8'(k), 0);
      tick();
    end
    chk("fill_count", {30'b0, count}, 3);
    chk("fill_in_ready", {31'b0, in_ready}, 0);
    chk("fill_out_data", {24'b0, out_data}, 1);
    set(1, 0, 0, 0, 1);
    tick();
    chk("pop_out_data", {24'b0, out_data}, 2);
    chk("pop_count", {30'b0, count}, 2);
    chk("pop_in_ready", {31'b0, in_ready}, 1);
    drain();

    // bubble collapse behind a stalled output
    set(1, 0, 1, 8'h01, 0); tick();
    set(1, 0, 0, 8'h00, 0); tick(); tick();
    set(1, 0, 1, 8'h02, 0); tick();
    set(1, 0, 0, 8'h00, 0); tick();
    chk("bub_count", {30'b0, count}, 2);
    chk("bub_out_data", {24'b0, out_data}, 1);
    chk("bub_in_ready", {31'b0, in_ready}, 1);
    drain();

    // flush a full pipeline while an output handshake and an input are offered
    for (int k = 0; k < 3; k++) begin
      set(1, 0, 1, 8'(8'h11 + k), 0);
      tick();
    end
    set(1, 1, 1, 8'h99, 1);
    #1 chk("flush_in_ready", {31'b0, in_ready}, 0);
    tick();
    set(1, 0, 0, 0, 0);
    #1;
    chk("flush_count", {30'b0, count}, 0);
    chk("flush_out_valid", {31'b0, out_valid}, 0);
    chk("flush_out_data", {24'b0, out_data}, 32'hA5);

    // clock enable low mid-stream, including a flush that must be ignored
    for (int k = 0; k < 2; k++) begin
      set(1, 0, 1, 8'(8'h40 + k), 1);
      tick();
    end
    cnt_hold = count;
    for (int k = 0; k < 4; k++) begin
      set(0, (k == 1), 1, 8'h77, 1);
      #1 chk("ce_in_ready", {31'b0, in_ready}, 0);
      tick();
      chk("ce_count", {30'b0, count}, {30'b0, cnt_hold});
    end
    set(1, 0, 1, 8'h50, 1); tick(); tick();

    // asynchronous reset pulse mid-stream
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_count", {30'b0, count}, 0);
    chk("arst_out_data", {24'b0, out_data}, 32'hA5);
    chk("arst_in_ready", {31'b0, in_ready}, 0);
    tick();
    rst = 1'b0;
    tick();
    drain();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      set(($urandom_range(99) < 90), ($urandom_range(99) < 4), $urandom_range(1),
          8'($urandom), ($urandom_range(99) < 60));
      rst = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/reg_pipeline.md
Name: reg_pipeline

Overview:
- Parametrised successor to the single-bit flip-flop primitives: a DEPTH-stage, WIDTH-bit register pipeline.
- Adds a valid/ready handshake, per-stage bubble collapse, synchronous flush, a global clock enable and a configurable reset value.
- Used as the standard retiming/skid element between datapath blocks, in place of hand-chained flops.

Parameters:
- WIDTH, 8: data width in bits (>=1).
- DEPTH, 3: number of register stages (>=1); stage 0 is the input side, stage DEPTH-1 drives the outputs.
- RESET_VAL, 0: value loaded into every data register on reset and on flush (WIDTH bits).
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable; when 0 all state holds, in_ready=0, out_valid still reflects the last stage.
- flush  in  1  synchronous clear of all stages; takes priority over every handshake.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  pipeline can accept in_data this cycle.
- in_data  in  WIDTH  upstream data.
- out_valid  out  1  stage DEPTH-1 holds valid data.
- out_ready  in  1  downstream accepts out_data this cycle.
- out_data  out  WIDTH  stage DEPTH-1 data register.
- count  out  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- State per stage i: v[i] (valid) and d[i] (data).
- Reset (rst=1, asynchronous):
  - all v[i]=0 and all d[i]=RESET_VAL.
  - outputs: out_valid=0, out_data=RESET_VAL, count=0, in_ready=0 while rst is asserted.
- Stage advance enable, computed combinationally from the output end backwards:
  - adv[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - adv[i] = ~v[i] | adv[i+1].
- Handshake outputs:
  - in_ready = ce & ~flush & adv[0].
  - out_valid = v[DEPTH-1], out_data = d[DEPTH-1] (registered; no combinational path from in_data).
- On a clock edge with ce=1, flush=0, for each stage:
  - Stage 0: if adv[0], then v[0] <= in_valid and d[0] <= in_data when in_valid; else hold.
  - Stage i>0: if adv[i], then v[i] <= v[i-1] and d[i] <= d[i-1] when v[i-1]; else hold.
  - Data registers load only when their incoming valid is 1. Bubbles do not overwrite data.
- Bubble collapse: a stalled output does not stall upstream stages that hold bubbles. Empty stages keep filling until the pipeline is full.
- Latency: DEPTH cycles from input handshake to out_valid with no stall. Throughput: 1 transfer per cycle when out_ready=1.
- Flush (ce=1, flush=1):
  - next edge: all v[i]=0 and all d[i]=RESET_VAL.
  - in_ready=0 during flush, so no input is accepted; in_valid in the same cycle is dropped.
  - An output handshake in the flush cycle (out_valid & out_ready) still completes. That data is considered consumed.
- ce=0: every register holds, including during flush. Flush takes effect only on an enabled edge.
- count:
  - registered, equal to the number of set v[i] after each edge.
  - +1 on input accept only, -1 on output accept only, unchanged on both or neither.
  - 0 after flush or reset.
- Full (count=DEPTH) with out_ready=0: in_ready=0 and all stages hold.
- Full with out_ready=1: simultaneous accept and emit; count stays DEPTH.
- DEPTH=1: behaves as a single flop with a handshake. in_ready = ce & ~flush & (~v[0] | out_ready).
- rst asserted mid-transfer: all in-flight data is discarded immediately. No partial outputs appear after release.

Test Plan:
- Reset release, DEPTH=3, WIDTH=8, RESET_VAL=8'hA5 -> out_valid=0, out_data=8'hA5, count=0, and in_ready=1 on the first cycle with ce=1.
- Stream 8'h01..8'h06 with in_valid=1, out_ready=1 -> out_valid rises 3 cycles after the first accept; outputs 01..06 on consecutive cycles, in order; count holds at 3 during steady state.
- out_ready=0 and inject 01, 02, 03 -> fill: count reaches 3, in_ready=0 after the third accept, out_data=01. Then set out_ready=1 for one cycle -> out_data=02, count=2, in_ready=1.
- Bubble collapse: inject 01, idle 2 cycles, inject 02 with out_ready=0 -> 02 advances to stage 1 behind 01 without a stall; count=2.
- Flush with a full pipeline, in_valid=1, out_ready=1 -> the current out_data is consumed; the new input is not accepted; the next cycle has count=0, out_valid=0, out_data=8'hA5.
- ce=0 for 4 cycles mid-stream, and rst pulsed for 1 cycle mid-stream -> under ce=0, state is frozen with in_ready=0. Under rst, out_valid drops to 0 asynchronously before the next edge, and count=0.
